// File: rtl/vga_timing_if.sv
// Raster timing bundle shared by the timing generator and the pixel-colour stages.
interface vga_timing_if;
   logic       pix_en;
   logic [9:0] hCount;
   logic [9:0] vCount;
   logic       hSync;
   logic       vSync;
   logic       bright;
   logic       line_end;
   logic       frame_end;

   modport master (
      output pix_en, hCount, vCount, hSync, vSync, bright, line_end, frame_end
   );

   modport slave (
      input pix_en, hCount, vCount, hSync, vSync, bright, line_end, frame_end
   );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel-enable divider, h/v counters,
// registered sync/visible decode and line/frame end strobes.
module vga_timing_gen #(
   parameter int DIV         = 4,
   parameter int H_TOTAL     = 800,
   parameter int H_SYNC      = 96,
   parameter int H_VIS_START = 144,
   parameter int H_VIS_END   = 784,
   parameter int V_TOTAL     = 525,
   parameter int V_SYNC      = 2,
   parameter int V_VIS_START = 35,
   parameter int V_VIS_END   = 515
) (
   input  logic           clk,
   input  logic           rst,
   vga_timing_if.master   vga
);

   localparam int DW = $clog2(DIV);

   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0]    H_SYNC_W  = 10'(H_SYNC);
   localparam logic [9:0]    V_SYNC_W  = 10'(V_SYNC);
   localparam logic [9:0]    H_VS_W    = 10'(H_VIS_START);
   localparam logic [9:0]    H_VE_W    = 10'(H_VIS_END);
   localparam logic [9:0]    V_VS_W    = 10'(V_VIS_START);
   localparam logic [9:0]    V_VE_W    = 10'(V_VIS_END);

   logic [DW-1:0] div_cnt;
   logic [9:0]    h_cnt;
   logic [9:0]    v_cnt;
   logic [9:0]    h_nxt;
   logic [9:0]    v_nxt;
   logic          pix_en;
   logic          h_last;
   logic          v_last;
   logic          h_sync_r;
   logic          v_sync_r;
   logic          bright_r;

   assign pix_en = (div_cnt == DIV_LAST);
   assign h_last = (h_cnt == H_LAST);
   assign v_last = (v_cnt == V_LAST);

   // Clock divider: free-running 0..DIV-1, pix_en marks the final clk of a pixel.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         div_cnt <= '0;
      else if (pix_en)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   // Next raster position; wrap wins over increment so counters stay below TOTAL.
   always_comb begin
      h_nxt = h_cnt;
      v_nxt = v_cnt;
      if (pix_en) begin
         if (h_last) begin
            h_nxt = '0;
            v_nxt = v_last ? 10'd0 : v_cnt + 10'd1;
         end else begin
            h_nxt = h_cnt + 10'd1;
         end
      end
   end

   // Counters and decode registers; decode uses next values so it lines up with the counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_cnt    <= '0;
         v_cnt    <= '0;
         h_sync_r <= 1'b0;
         v_sync_r <= 1'b0;
         bright_r <= 1'b0;
      end else begin
         h_cnt    <= h_nxt;
         v_cnt    <= v_nxt;
         h_sync_r <= !(h_nxt < H_SYNC_W);
         v_sync_r <= !(v_nxt < V_SYNC_W);
         bright_r <= (h_nxt >= H_VS_W) && (h_nxt < H_VE_W) &&
                     (v_nxt >= V_VS_W) && (v_nxt < V_VE_W);
      end
   end

   assign vga.pix_en    = pix_en;
   assign vga.hCount    = h_cnt;
   assign vga.vCount    = v_cnt;
   assign vga.hSync     = h_sync_r;
   assign vga.vSync     = v_sync_r;
   assign vga.bright    = bright_r;
   assign vga.line_end  = pix_en && h_last;
   assign vga.frame_end = pix_en && h_last && v_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-geometry instance and a shrunken-geometry
// instance share clock and reset; both are compared every clk against a model
// that derives the raster position from the number of clk edges since reset.
module tb_vga_timing_gen;

   // Shrunken geometry so whole frames fit in a short run.
   localparam int S_DIV = 4;
   localparam int S_HT  = 40;
   localparam int S_HS  = 5;
   localparam int S_HVS = 8;
   localparam int S_HVE = 36;
   localparam int S_VT  = 12;
   localparam int S_VS  = 2;
   localparam int S_VVS = 3;
   localparam int S_VVE = 10;

   logic clk;
   logic rst;

   vga_timing_if vga_def ();
   vga_timing_if vga_sml ();

   vga_timing_gen dut_def (
      .clk (clk),
      .rst (rst),
      .vga (vga_def)
   );

   vga_timing_gen #(
      .DIV(S_DIV), .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_VIS_START(S_HVS),
      .H_VIS_END(S_HVE), .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_VIS_START(S_VVS),
      .V_VIS_END(S_VVE)
   ) dut_sml (
      .clk (clk),
      .rst (rst),
      .vga (vga_sml)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int n     = 0;

   // Shrunken-instance statistics over whole lines/frames.
   int  frame_clk, bright_pix, h_low, v_low;
   bit  line_valid, frame_valid;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s n=%0d observed=%0d expected=%0d", tag, n, obs, exp);
      end
   endtask

   // Expected raster from clk edges since reset, using plain arithmetic.
   task automatic check_inst(
      input string nm, input int cyc,
      input int dv, input int ht, input int hs, input int hvs, input int hve,
      input int vt, input int vs, input int vvs, input int vve,
      input logic pe, input logic [9:0] hc, input logic [9:0] vc,
      input logic hsy, input logic vsy, input logic br,
      input logic le, input logic fe);
      int  p, h, v;
      bit  e_pe, e_le, e_fe;
      p    = cyc / dv;
      h    = p % ht;
      v    = (p / ht) % vt;
      e_pe = (cyc % dv) == dv - 1;
      e_le = e_pe && (h == ht - 1);
      e_fe = e_le && (v == vt - 1);
      chk({nm, ".pix_en"},    32'(pe),  32'(e_pe));
      chk({nm, ".hCount"},    32'(hc),  32'(h));
      chk({nm, ".vCount"},    32'(vc),  32'(v));
      chk({nm, ".hSync"},     32'(hsy), 32'(!(h < hs)));
      chk({nm, ".vSync"},     32'(vsy), 32'(!(v < vs)));
      chk({nm, ".bright"},    32'(br),  32'(h >= hvs && h < hve && v >= vvs && v < vve));
      chk({nm, ".line_end"},  32'(le),  32'(e_le));
      chk({nm, ".frame_end"}, 32'(fe),  32'(e_fe));
   endtask

   task automatic check_all();
      check_inst("def", n, 4, 800, 96, 144, 784, 525, 2, 35, 515,
                 vga_def.pix_en, vga_def.hCount, vga_def.vCount, vga_def.hSync,
                 vga_def.vSync, vga_def.bright, vga_def.line_end, vga_def.frame_end);
      check_inst("sml", n, S_DIV, S_HT, S_HS, S_HVS, S_HVE, S_VT, S_VS, S_VVS, S_VVE,
                 vga_sml.pix_en, vga_sml.hCount, vga_sml.vCount, vga_sml.hSync,
                 vga_sml.vSync, vga_sml.bright, vga_sml.line_end, vga_sml.frame_end);
   endtask

   task automatic clear_stats();
      frame_clk   = 0;
      bright_pix  = 0;
      h_low       = 0;
      v_low       = 0;
      line_valid  = 0;
      frame_valid = 0;
   endtask

   // Measured widths/periods on the shrunken instance, checked once a full span is seen.
   task automatic update_stats();
      frame_clk++;
      if (vga_sml.bright && vga_sml.pix_en) bright_pix++;
      if (!vga_sml.hSync) h_low++;
      if (!vga_sml.vSync) v_low++;
      if (vga_sml.line_end) begin
         if (line_valid) chk("sml.hsync_low_clk", 32'(h_low), 32'(S_HS * S_DIV));
         h_low      = 0;
         line_valid = 1;
      end
      if (vga_sml.frame_end) begin
         if (frame_valid) begin
            chk("sml.frame_period", 32'(frame_clk),  32'(S_HT * S_VT * S_DIV));
            chk("sml.bright_pix",   32'(bright_pix), 32'((S_HVE - S_HVS) * (S_VVE - S_VVS)));
            chk("sml.vsync_low_clk", 32'(v_low),     32'(S_VS * S_HT * S_DIV));
         end
         frame_clk   = 0;
         bright_pix  = 0;
         v_low       = 0;
         frame_valid = 1;
      end
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         check_all();
         update_stats();
      end
   endtask

   initial begin
      rst = 1'b0;
      clear_stats();
      repeat (5) @(negedge clk);
      check_all();
      #1 rst = 1'b1;
      n = 0;
      check_all();
      update_stats();
      // Covers pix_en on clk 4, the default line wrap at (799,10) and many small frames.
      run(36100);

      // Asynchronous reset pulses at random points, between clk edges.
      for (int k = 0; k < 3; k++) begin
         run($urandom_range(3000, 100));
         #1 rst = 1'b0;
         #1;
         n = 0;
         check_all();
         #1 rst = 1'b1;
         clear_stats();
         update_stats();
         run(4000);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
